immgen_pipe: RTL and testbench
==============================

IMMGEN_PIPE -- requirements
Module: immgen_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the immediate output width; legal values are 32 and 64.
REQ-002 Parameter RVC_EN, default 1, SHALL enable decoding of 16-bit compressed immediates (1) or flag them illegal (0).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port flush  input  1  SHALL discard the held output entry.
REQ-006 Port in_valid  input  1  SHALL indicate that in_instr is valid.
REQ-007 Port in_ready  output  1  SHALL indicate that the stage accepts an input this cycle.
REQ-008 Port in_instr  input  32  SHALL carry the raw instruction word; a 16-bit instruction occupies bits [15:0].
REQ-009 Port out_valid  output  1  SHALL indicate that the out_* fields are valid.
REQ-010 Port out_ready  input  1  SHALL indicate that the consumer accepts the output.
REQ-011 Port out_imm  output  XLEN  SHALL carry the selected, extended immediate.
REQ-012 Port out_fmt  output  3  SHALL carry the format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 ILLEGAL.
REQ-013 Port out_is_rvc  output  1  SHALL be set when the held entry is a compressed instruction.

Function
REQ-014 Single-entry pipeline register; in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-015 A transfer occurs when in_valid && in_ready; the decoded result SHALL appear on the out_* ports on the next cycle with out_valid=1 (latency 1).
REQ-016 While out_valid && !out_ready, all out_* ports SHALL hold stable.
REQ-017 Output consumed with no new transfer in the same cycle: out_valid SHALL go to 0 next cycle.
REQ-018 Output consumed with a new transfer in the same cycle: out_valid SHALL stay 1 and load the new entry (full throughput, no bubble).
REQ-019 flush SHALL force out_valid=0 next cycle and block any input transfer in that cycle; flush SHALL take priority over in_valid and out_ready.
REQ-020 32-bit decode (in_instr[1:0]=11), by opcode:
- LOAD, OP-IMM, JALR, FENCE -> I
- STORE -> S
- BRANCH -> B
- LUI, AUIPC -> U
- JAL -> J
- OP -> NONE
- SYSTEM with funct3 in {101,110,111} -> Z
- other SYSTEM -> I
- OP-IMM-32 (0011011) -> I only when XLEN=64, otherwise ILLEGAL
- any other opcode -> ILLEGAL
REQ-021 I/S/B/U/J immediates SHALL follow the RV32I field layouts, sign-extended from instr[31] to XLEN; U-type SHALL be {instr[31:12],12'b0} sign-extended to XLEN.
REQ-022 Z-type immediate SHALL be instr[19:15] zero-extended to XLEN.
REQ-023 Compressed decode (RVC_EN=1, in_instr[1:0]!=11) SHALL ignore in_instr[31:16] and decode:
- C.ADDI, C.LI -> I, sext{i[12],i[6:2]}
- C.LW, C.SW -> I or S respectively, zext{i[5],i[12:10],i[6],2'b0}
- C.LWSP -> I, zext{i[3:2],i[12],i[6:4],2'b0}
- C.J -> J, sext{i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],0}
- C.BEQZ, C.BNEZ -> B, sext{i[12],i[6:5],i[2],i[11:10],i[4:3],0}
- C.LUI (rd!=0,2) -> U, sext{i[12],i[6:2]}<<12
- any other compressed encoding -> NONE
REQ-024 in_instr[15:0]==16'h0000 SHALL give ILLEGAL regardless of RVC_EN; RVC_EN=0 with in_instr[1:0]!=11 SHALL give ILLEGAL.
REQ-025 For NONE and ILLEGAL formats, out_imm SHALL be 0.
REQ-026 out_is_rvc SHALL be 1 exactly when in_instr[1:0]!=11 (including the ILLEGAL cases).

Reset
REQ-027 While rst=1, out_valid, out_imm, out_fmt and out_is_rvc SHALL be 0 on the next edge, and in_ready SHALL be 0.
REQ-028 rst asserted mid-stall SHALL drop the held entry; the first transfer SHALL be accepted the cycle after rst deasserts.

Verification
REQ-029 XLEN=32: in 0xFFF00093 (addi) -> next cycle out_imm=0xFFFFFFFF, fmt=1, is_rvc=0.
REQ-030 in 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=3; XLEN=64: in 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, fmt=4.
REQ-031 RVC_EN=1: in 0x000050FD (c.li x1,-1) -> out_imm=0xFFFFFFFF, fmt=1, is_rvc=1; RVC_EN=0: same input -> fmt=7, imm=0.
REQ-032 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 with in_valid=1 -> back-to-back transfers every cycle.
REQ-033 flush=1 during a stall with in_valid=1 -> out_valid=0 next cycle, no input accepted; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/immgen_pipe.sv
// Immediate generator pipeline stage: decodes RV32/RV64 and RVC immediates
// into a single registered entry with a valid/ready handshake.
module immgen_pipe #(
    parameter int XLEN   = 32,
    parameter bit RVC_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_is_rvc
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    logic [31:0] i;
    logic        rvc;
    logic        zero16;
    logic [2:0]  fmt32, fmt16, fmt_d;
    logic [31:0] imm32, imm16, imm_d;
    logic [31:0] c_ci;

    assign i      = in_instr;
    assign rvc    = i[1:0] != 2'b11;
    assign zero16 = i[15:0] == 16'h0000;
    assign c_ci   = {{26{i[12]}}, i[12], i[6:2]};

    always_comb begin
        fmt32 = FMT_ILL;
        imm32 = '0;
        case (i[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
                fmt32 = FMT_I;
                imm32 = {{20{i[31]}}, i[31:20]};
            end
            OP_STORE: begin
                fmt32 = FMT_S;
                imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            OP_BR: begin
                fmt32 = FMT_B;
                imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt32 = FMT_U;
                imm32 = {i[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt32 = FMT_J;
                imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            OP_OP: fmt32 = FMT_NONE;
            OP_SYS: begin
                if (i[14:12] >= 3'b101) begin
                    fmt32 = FMT_Z;
                    imm32 = {27'b0, i[19:15]};
                end else begin
                    fmt32 = FMT_I;
                    imm32 = {{20{i[31]}}, i[31:20]};
                end
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    fmt32 = FMT_I;
                    imm32 = {{20{i[31]}}, i[31:20]};
                end
            end
            default: ;
        endcase
    end

    // Quadrant and funct3 together select the compressed form.
    always_comb begin
        fmt16 = FMT_NONE;
        imm16 = '0;
        case ({i[1:0], i[15:13]})
            5'b00_010, 5'b00_110: begin
                fmt16 = i[15] ? FMT_S : FMT_I;
                imm16 = {25'b0, i[5], i[12:10], i[6], 2'b0};
            end
            5'b01_000, 5'b01_010: begin
                fmt16 = FMT_I;
                imm16 = c_ci;
            end
            5'b01_011: begin
                if (i[11:7] != 5'd0 && i[11:7] != 5'd2) begin
                    fmt16 = FMT_U;
                    imm16 = {c_ci[19:0], 12'b0};
                end
            end
            5'b01_101: begin
                fmt16 = FMT_J;
                imm16 = {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7],
                         i[2], i[11], i[5:3], 1'b0};
            end
            5'b01_110, 5'b01_111: begin
                fmt16 = FMT_B;
                imm16 = {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10],
                         i[4:3], 1'b0};
            end
            5'b10_010: begin
                fmt16 = FMT_I;
                imm16 = {24'b0, i[3:2], i[12], i[6:4], 2'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        fmt_d = FMT_ILL;
        imm_d = '0;
        unique case (1'b1)
            !rvc:                       begin fmt_d = fmt32; imm_d = imm32; end
            rvc && zero16:              fmt_d = FMT_ILL;
            rvc && !zero16 && !RVC_EN:  fmt_d = FMT_ILL;
            rvc && !zero16 && RVC_EN:   begin fmt_d = fmt16; imm_d = imm16; end
        endcase
        if (fmt_d == FMT_NONE || fmt_d == FMT_ILL)
            imm_d = '0;
    end

    assign in_ready = (!out_valid || out_ready) && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= FMT_NONE;
            out_is_rvc <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid  <= 1'b1;
            out_imm    <= XLEN'($signed(imm_d));
            out_fmt    <= fmt_d;
            out_is_rvc <= rvc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Self-checking bench for immgen_pipe: three configurations driven in
// lockstep and compared against a field-arithmetic reference decoder.
module tb_immgen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic        rdy [3];
    logic        vld [3];
    logic [2:0]  fmt [3];
    logic        isr [3];
    logic [31:0] imm_a, imm_c;
    logic [63:0] imm_b;

    // instance 0: XLEN32 RVC on, 1: XLEN64 RVC on, 2: XLEN32 RVC off
    localparam logic [2:0] X64 = 3'b010;
    localparam logic [2:0] RVM = 3'b011;

    immgen_pipe #(.XLEN(32), .RVC_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy[0]), .in_instr(in_instr), .out_valid(vld[0]),
        .out_ready(out_ready), .out_imm(imm_a), .out_fmt(fmt[0]),
        .out_is_rvc(isr[0]));

    immgen_pipe #(.XLEN(64), .RVC_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy[1]), .in_instr(in_instr), .out_valid(vld[1]),
        .out_ready(out_ready), .out_imm(imm_b), .out_fmt(fmt[1]),
        .out_is_rvc(isr[1]));

    immgen_pipe #(.XLEN(32), .RVC_EN(1'b0)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy[2]), .in_instr(in_instr), .out_valid(vld[2]),
        .out_ready(out_ready), .out_imm(imm_c), .out_fmt(fmt[2]),
        .out_is_rvc(isr[2]));

    int nerr = 0;
    int nchk = 0;

    bit          ev = 1'b0;
    logic [2:0]  ef [3];
    logic [63:0] ei [3];
    logic        er [3];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] oimm(input int k);
        if (k == 0) return {32'b0, imm_a};
        if (k == 1) return imm_b;
        return {32'b0, imm_c};
    endfunction

    function automatic longint u(input logic [31:0] x);
        return longint'(x);
    endfunction

    function automatic longint sx(input longint v, input int b);
        return v[b-1] ? v - (longint'(1) << b) : v;
    endfunction

    function automatic void refdec(input logic [31:0] i, input bit x64,
                                   input bit rvc, output logic [2:0] f,
                                   output logic [63:0] m, output logic c);
        longint v, iimm, ci;
        v    = 0;
        f    = 3'd7;
        c    = (i[1:0] != 2'b11);
        iimm = sx(u(i[31:20]), 12);
        ci   = sx(u(i[12]) * 32 + u(i[6:2]), 6);
        if (i[15:0] == 16'h0000) begin
            f = 3'd7;
        end else if (!c) begin
            case (i[6:0])
                7'h03, 7'h13, 7'h67, 7'h0F: begin f = 1; v = iimm; end
                7'h23: begin
                    f = 2;
                    v = sx(u(i[31:25]) * 32 + u(i[11:7]), 12);
                end
                7'h63: begin
                    f = 3;
                    v = sx(u(i[31]) * 4096 + u(i[7]) * 2048
                           + u(i[30:25]) * 32 + u(i[11:8]) * 2, 13);
                end
                7'h37, 7'h17: begin f = 4; v = sx(u(i[31:12]), 20) * 4096; end
                7'h6F: begin
                    f = 5;
                    v = sx(u(i[31]) * (1 << 20) + u(i[19:12]) * 4096
                           + u(i[20]) * 2048 + u(i[30:21]) * 2, 21);
                end
                7'h33: f = 0;
                7'h73: begin
                    if (i[14:12] >= 5) begin f = 6; v = u(i[19:15]); end
                    else begin f = 1; v = iimm; end
                end
                7'h1B: if (x64) begin f = 1; v = iimm; end
                default: f = 7;
            endcase
        end else if (!rvc) begin
            f = 3'd7;
        end else begin
            f = 0;
            case ({i[1:0], i[15:13]})
                5'b00_010, 5'b00_110: begin
                    f = i[15] ? 3'd2 : 3'd1;
                    v = u(i[5]) * 64 + u(i[12:10]) * 8 + u(i[6]) * 4;
                end
                5'b01_000, 5'b01_010: begin f = 1; v = ci; end
                5'b01_011:
                    if (i[11:7] != 0 && i[11:7] != 2) begin
                        f = 4; v = ci * 4096;
                    end
                5'b01_101: begin
                    f = 5;
                    v = sx(u(i[12]) * 2048 + u(i[8]) * 1024 + u(i[10:9]) * 256
                           + u(i[6]) * 128 + u(i[7]) * 64 + u(i[2]) * 32
                           + u(i[11]) * 16 + u(i[5:3]) * 2, 12);
                end
                5'b01_110, 5'b01_111: begin
                    f = 3;
                    v = sx(u(i[12]) * 256 + u(i[6:5]) * 64 + u(i[2]) * 32
                           + u(i[11:10]) * 8 + u(i[4:3]) * 2, 9);
                end
                5'b10_010: begin
                    f = 1;
                    v = u(i[3:2]) * 64 + u(i[12]) * 32 + u(i[6:4]) * 4;
                end
                default: f = 0;
            endcase
        end
        if (f == 0 || f == 7) v = 0;
        if (!x64) v = sx(v & 64'hFFFF_FFFF, 32);
        m = v;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 12))
            0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h67;  3: op = 7'h0F;
            4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;
            8: op = 7'h6F;  9: op = 7'h33;  10: op = 7'h73; 11: op = 7'h1B;
            default: op = 7'h3B;
        endcase
        case ($urandom_range(0, 5))
            0, 1, 2: r[6:0] = op;
            3: ;
            4: r[1:0] = 2'($urandom_range(0, 2));
            default: r[15:0] = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic step(input bit v, input logic [31:0] ins, input bit ordy,
                        input bit fl, input bit r);
        bit erdy;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        erdy = (!ev || ordy) && !fl && !r;
        for (int k = 0; k < 3; k++)
            chk($sformatf("in_ready[%0d]", k), 64'(rdy[k]), 64'(erdy));
        @(posedge clk);
        #1;
        if (r) begin
            ev = 1'b0;
            for (int k = 0; k < 3; k++) begin
                ef[k] = 3'd0; ei[k] = 64'd0; er[k] = 1'b0;
            end
        end else if (fl) begin
            ev = 1'b0;
        end else if (v && erdy) begin
            ev = 1'b1;
            for (int k = 0; k < 3; k++)
                refdec(ins, X64[k], RVM[k], ef[k], ei[k], er[k]);
        end else if (ordy) begin
            ev = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid[%0d]", k), 64'(vld[k]), 64'(ev));
            if (ev || r) begin
                chk($sformatf("out_fmt[%0d]", k), 64'(fmt[k]), 64'(ef[k]));
                chk($sformatf("out_is_rvc[%0d]", k), 64'(isr[k]), 64'(er[k]));
                chk($sformatf("out_imm[%0d]", k), oimm(k),
                    X64[k] ? ei[k] : {32'b0, ei[k][31:0]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_instr = '0;

        step(1, 32'hFFF00093, 1, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        chk("rst_imm64", imm_b, 64'd0);

        step(1, 32'hFFF00093, 1, 0, 0);
        chk("addi_imm", 64'(imm_a), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(fmt[0]), 64'd1);
        chk("addi_rvc", 64'(isr[0]), 64'd0);

        step(1, 32'hFE000EE3, 1, 0, 0);
        chk("beq_imm", 64'(imm_a), 64'hFFFF_FFFC);
        chk("beq_fmt", 64'(fmt[0]), 64'd3);

        step(1, 32'h800000B7, 1, 0, 0);
        chk("lui64_imm", imm_b, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_fmt", 64'(fmt[1]), 64'd4);

        step(1, 32'h000050FD, 1, 0, 0);
        chk("cli_imm", 64'(imm_a), 64'hFFFF_FFFF);
        chk("cli_fmt", 64'(fmt[0]), 64'd1);
        chk("cli_rvc", 64'(isr[0]), 64'd1);
        chk("norvc_fmt", 64'(fmt[2]), 64'd7);
        chk("norvc_imm", 64'(imm_c), 64'd0);

        for (int n = 0; n < 5; n++) step(1, gen(), 0, 0, 0);
        chk("stall_imm", 64'(imm_a), 64'hFFFF_FFFF);
        chk("stall_rdy", 64'(rdy[0]), 64'd0);

        for (int n = 0; n < 6; n++) step(1, gen(), 1, 0, 0);

        step(1, gen(), 0, 0, 0);
        step(1, gen(), 0, 1, 0);
        chk("flush_valid", 64'(vld[0]), 64'd0);
        step(0, gen(), 0, 0, 0);

        step(1, 32'h00C00013, 1, 0, 0);
        step(1, gen(), 0, 0, 0);
        step(1, gen(), 0, 0, 1);
        chk("rst_stall_imm", 64'(imm_a), 64'd0);
        step(1, 32'h00C00013, 1, 0, 0);
        chk("post_rst_imm", 64'(imm_a), 64'd12);

        step(1, 32'hABCD0000, 1, 0, 0);
        chk("zero16_fmt", 64'(fmt[1]), 64'd7);
        chk("zero16_rvc", 64'(isr[1]), 64'd1);

        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
